// File: rtl/semafor_unit.sv
// Single-slot mailbox semaphore: one writer deposits a word and readers peek at it or release it.
// Ready outputs are combinational from the registered slot state.
module semafor_unit #(
    parameter int unsigned DATA_W    = 1,
    parameter bit          INIT_FULL = 1'b0
) (
    input  logic              clk_i,
    input  logic              clr_ni,
    input  logic [DATA_W-1:0] di_i,
    output logic [DATA_W-1:0] dq_o,
    input  logic              wr_i,
    input  logic              wr_en_i,
    output logic              wr_rdy_o,
    input  logic              rd_i,
    input  logic              rd_en_i,
    output logic              rd_rdy_o,
    input  logic              realase_i
);

    typedef enum logic [0:0] {StEmpty = 1'b0, StFull = 1'b1} state_e;

    localparam state_e ResetState = INIT_FULL ? StFull : StEmpty;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_go, rel_go;

    // Both requests are judged against the registered state, so at most one can act per cycle.
    assign wr_go  = wr_i & wr_en_i & (state_q == StEmpty);
    assign rel_go = rd_i & rd_en_i & realase_i & (state_q == StFull);

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q <= ResetState;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            StEmpty: begin
                if (wr_go) begin
                    state_d = StFull;
                    data_d  = di_i;
                end
            end
            StFull: begin
                // The data register is kept on release so DQ still shows the last value.
                if (rel_go) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_comb begin
        wr_rdy_o = wr_go;
        rd_rdy_o = (state_q == StFull);
        dq_o     = data_q;
    end

endmodule

// File: tb/tb_semafor_unit.sv
// Bench for semafor_unit: queue-based slot model checked every cycle, plus directed literal checks.
module tb_semafor_unit;

    localparam int unsigned DW = 1;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] di = '0;
    logic [DW-1:0] dq;
    logic          wr = 1'b0, wr_en = 1'b0, rd = 1'b0, rd_en = 1'b0, realase = 1'b0;
    logic          wr_rdy, rd_rdy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    semafor_unit #(.DATA_W(DW), .INIT_FULL(1'b0)) dut (
        .clk_i    (clk),
        .clr_ni   (clr),
        .di_i     (di),
        .dq_o     (dq),
        .wr_i     (wr),
        .wr_en_i  (wr_en),
        .wr_rdy_o (wr_rdy),
        .rd_i     (rd),
        .rd_en_i  (rd_en),
        .rd_rdy_o (rd_rdy),
        .realase_i(realase)
    );

    always #5 clk = ~clk;

    // Model: the slot is a queue holding at most one word; shown is the last word ever deposited.
    logic [DW-1:0] slot[$];
    logic [DW-1:0] shown = '0;

    initial begin
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                slot.delete();
                shown = '0;
            end else if (slot.size() == 0) begin
                if (wr && wr_en) begin
                    slot.push_back(di);
                    shown = di;
                end
            end else if (rd && rd_en && realase) begin
                void'(slot.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("model_wr_rdy", 32'(wr_rdy), 32'(wr && wr_en && slot.size() == 0));
            check("model_rd_rdy", 32'(rd_rdy), 32'(slot.size() != 0));
            check("model_dq", 32'(dq), 32'(shown));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 0; wr_en = 0; rd = 0; rd_en = 0; realase = 0; di = '0;
    endtask

    initial begin
        idle();
        clr = 0;
        tick(); tick();
        #1;
        check("reset_dq", 32'(dq), 0);
        check("reset_rd_rdy", 32'(rd_rdy), 0);
        check("reset_wr_rdy", 32'(wr_rdy), 0);
        clr = 1;
        tick();

        // Write then peek
        wr = 1; wr_en = 1; di = 1;
        #1 check("write_ack", 32'(wr_rdy), 1);
        tick(); idle();
        #1;
        check("write_dq", 32'(dq), 1);
        check("write_full", 32'(rd_rdy), 1);
        check("full_wr_rdy_idle", 32'(wr_rdy), 0);
        rd = 1; rd_en = 1; realase = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("peek_rd_rdy", 32'(rd_rdy), 1);
            check("peek_dq", 32'(dq), 1);
        end

        // Release keeps the data visible
        realase = 1;
        tick(); idle();
        #1;
        check("release_rd_rdy", 32'(rd_rdy), 0);
        check("release_dq", 32'(dq), 1);

        wr = 1; wr_en = 1; di = 1;
        tick(); idle();

        // Write to full with release in the same cycle
        wr = 1; wr_en = 1; di = 0; rd = 1; rd_en = 1; realase = 1;
        #1;
        check("wfull_wr_rdy", 32'(wr_rdy), 0);
        check("wfull_dq", 32'(dq), 1);
        tick();
        rd = 0; rd_en = 0; realase = 0;
        #1;
        check("wfull_after_rel_wr_rdy", 32'(wr_rdy), 1);
        check("wfull_after_rel_rd_rdy", 32'(rd_rdy), 0);
        tick(); idle();
        #1;
        check("wfull_new_dq", 32'(dq), 0);
        check("wfull_new_full", 32'(rd_rdy), 1);

        // Qualifier gating
        rd = 1; rd_en = 0; realase = 1;
        tick();
        check("rd_no_en_full", 32'(rd_rdy), 1);
        rd_en = 1;
        tick(); idle();
        wr = 1; wr_en = 0; di = 1;
        #1 check("wr_no_en_rdy", 32'(wr_rdy), 0);
        tick(); idle();
        #1;
        check("wr_no_en_empty", 32'(rd_rdy), 0);
        check("wr_no_en_dq", 32'(dq), 0);
        rd = 1; rd_en = 1; realase = 1;
        #1 check("rd_empty_rdy", 32'(rd_rdy), 0);
        tick(); idle();
        #1 check("rd_empty_dq", 32'(dq), 0);

        // Async reset between edges
        wr = 1; wr_en = 1; di = 1;
        tick(); idle();
        #1 check("pre_clr_dq", 32'(dq), 1);
        #2 clr = 0;
        #1;
        check("async_clr_dq", 32'(dq), 0);
        check("async_clr_rd_rdy", 32'(rd_rdy), 0);
        tick();
        clr = 1;
        tick();

        // Sweep of input combinations against the model
        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i * 37 + 11);
            wr = v[0]; wr_en = v[1]; rd = v[2]; rd_en = v[3]; realase = v[4]; di = v[5];
            tick();
        end
        idle();
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/semafor_unit.md
Name: semafor_unit

Overview:
- Single-slot, one-bit mailbox semaphore between one writer CPU port and one or more reader CPU ports.
- Used in groups inside the multi-CPU semaphore bit memory.
- The writer deposits a bit and the slot becomes full. Readers may peek at it, or read-and-release it, which empties the slot.
- Ready outputs are combinational. The parent ORs them into each CPU's wait/ready line (high = proceed).

Parameters:
- DATA_W, 1, width of the stored value and of DI/DQ.
- INIT_FULL, 0, slot-full flag value after reset (0 = empty).

Ports:
- CLK  in  1  rising-edge clock.
- CLR  in  1  asynchronous active-low reset.
- DI  in  DATA_W  data from the writer port.
- DQ  out  DATA_W  stored data, continuously driven from the data register.
- WR  in  1  write request. Already includes write-enable and semaphore-address decode.
- WR_EN  in  1  writer address-match qualifier.
- WR_RDY  out  1  write accepted this cycle (writer may proceed).
- RD  in  1  read request, OR of all reader requests.
- RD_EN  in  1  reader address-match qualifier, OR of readers.
- RD_RDY  out  1  slot holds valid data (reader may proceed).
- REALASE  in  1  release qualifier. A read with REALASE=1 empties the slot.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While CLR=0: FULL=INIT_FULL, DATA=0, so DQ=0.
  - WR_RDY and RD_RDY follow the combinational equations below from the reset state.
- State: the FULL flag (EMPTY/FULL) and the DATA register. No other state.
- Combinational outputs:
  - WR_RDY = WR & WR_EN & ~FULL.
  - RD_RDY = FULL. The parent gates RD_RDY with its own address decode.
  - DQ = DATA at all times. Reading does not alter DQ.
- Write, on rising CLK: if WR & WR_EN & ~FULL, then DATA<=DI and FULL<=1.
- Write to a full slot:
  - WR_RDY=0 and nothing changes; the writer stalls.
  - The write proceeds in the first cycle after FULL returns to 0, with DI sampled in that cycle.
- Read-release, on rising CLK: if RD & RD_EN & REALASE & FULL, then FULL<=0. DATA is retained, so DQ still shows the last value.
- Peek: RD & RD_EN & FULL with REALASE=0 leaves FULL=1. Any number of peeks is allowed.
- Read of an empty slot: RD_RDY=0, no state change; the reader stalls.
- Simultaneous write and release in one cycle:
  - Decisions use registered FULL, so they never conflict.
  - If FULL=1, only the release acts.
  - If FULL=0, only the write acts.
- Latency:
  - Write acceptance is reported in the same cycle as the request; data is visible on DQ one cycle later.
  - RD_RDY rises one cycle after the accepted write and falls one cycle after the releasing read.
- RD or WR without the matching *_EN qualifier has no effect on state.
- Asserting CLR mid-operation discards the stored data and FULL immediately.

Test Plan:
1. Reset: CLR=0, then 1 with all inputs 0 -> FULL=0, DQ=0, RD_RDY=0, WR_RDY=0.
2. Write then peek:
   - WR=WR_EN=1, DI=1 -> WR_RDY=1 that cycle; next cycle DQ=1, RD_RDY=1.
   - RD=RD_EN=1, REALASE=0 for 3 cycles -> RD_RDY stays 1, DQ=1.
3. Release: from full, RD=RD_EN=1, REALASE=1 for 1 cycle -> next cycle RD_RDY=0, DQ stays 1.
4. Write to full:
   - From full, WR=WR_EN=1, DI=0 -> WR_RDY=0, DQ stays 1.
   - Release in the same cycle -> next cycle FULL=0, WR_RDY=1, and DQ=0 one cycle after that.
5. Qualifier gating:
   - WR=1, WR_EN=0 -> WR_RDY=0, no write.
   - RD=1, RD_EN=0, REALASE=1 while full -> FULL stays 1.
   - Read while empty -> RD_RDY=0, no change.
6. Async reset mid-operation: full with DQ=1, drop CLR between clock edges -> FULL=0 and DQ=0 immediately, without waiting for a CLK edge.
